// File: rtl/mod_stream_reducer_if.sv
// -----------------------------------------------------------------------------
// mod_stream_reducer_if
// Handshake and data bundle for mod_stream_reducer.
//   start    : master -> slave, request a new operation (honoured only when ready)
//   ready    : slave  -> master, block is idle and will accept start
//   in_data  : master -> slave, W-bit data word, most-significant word first
//   in_valid : master -> slave, in_data is valid this cycle
//   in_ready : slave  -> master, a word is consumed when in_valid && in_ready
//   done     : slave  -> master, one-cycle pulse when result is updated
//   result   : slave  -> master, RW-bit reduced value, registered
//   abort    : master -> slave, cancel a running operation; exists only when
//              MOD_REDUCER_ABORT_EN is defined
// Parameters: W = data word width, RW = result width (clog2 of the modulus).
// -----------------------------------------------------------------------------
interface mod_stream_reducer_if #(
    parameter int W  = 6,
    parameter int RW = 3
);
    logic          start;
    logic          ready;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic          done;
    logic [RW-1:0] result;
`ifdef MOD_REDUCER_ABORT_EN
    logic          abort;
`endif

    modport master (
`ifdef MOD_REDUCER_ABORT_EN
        output abort,
`endif
        output start,
        output in_data,
        output in_valid,
        input  ready,
        input  in_ready,
        input  done,
        input  result
    );

    modport slave (
`ifdef MOD_REDUCER_ABORT_EN
        input  abort,
`endif
        input  start,
        input  in_data,
        input  in_valid,
        output ready,
        output in_ready,
        output done,
        output result
    );
endinterface

// File: rtl/mod_stream_reducer.sv
// -----------------------------------------------------------------------------
// mod_stream_reducer
// Streams N words of W bits (most-significant first) and produces the value of
// their concatenation modulo M. The reduction is applied one word at a time
// (acc = {acc, word} mod M), so the accumulator never exceeds RW bits.
//
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : mod_stream_reducer_if.slave (start/ready, in_data/in_valid/in_ready,
//         done, result and, when enabled, abort)
//
// Optional feature: define MOD_REDUCER_ABORT_EN to add the abort input, which
// cancels a running operation without disturbing the last result.
// -----------------------------------------------------------------------------
module mod_stream_reducer #(
    parameter int W = 6,
    parameter int M = 7,
    parameter int N = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    mod_stream_reducer_if.slave   bus
);
    localparam int RW = $clog2(M);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int XW = RW + W;

    localparam logic [XW-1:0] M_EXT    = XW'(M);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    // One-hot encoding: each status output is a direct copy of one state bit.
    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_RUN  = 3'b010,
        ST_DONE = 3'b100
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [RW-1:0] acc_r;
    logic [CW-1:0] cnt_r;
    logic [RW-1:0] result_r;
    logic [RW-1:0] step_s;
    logic          abort_s;
    logic          accept_s;
    logic          last_s;

    // One reduction step: shift the running remainder up by one word and reduce.
    function automatic logic [RW-1:0] mod_step(input logic [RW-1:0] acc,
                                               input logic [W-1:0]  word);
        logic [XW-1:0] cat;
        logic [XW-1:0] rem;
        cat = {acc, word};
        rem = cat % M_EXT;
        return rem[RW-1:0];
    endfunction

`ifdef MOD_REDUCER_ABORT_EN
    assign abort_s = bus.abort;
`else
    assign abort_s = 1'b0;
`endif

    // A word presented in the same cycle as abort is refused.
    assign accept_s = state_r[1] & bus.in_valid & ~abort_s;
    assign last_s   = (cnt_r == CNT_LAST);
    assign step_s   = mod_step(acc_r, bus.in_data);

    assign bus.ready    = state_r[0];
    assign bus.in_ready = state_r[1] & ~abort_s;
    assign bus.done     = state_r[2];
    assign bus.result   = result_r;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort_s) begin
                    state_s = ST_IDLE;
                end else if (accept_s && last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Accumulator, word counter and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r    <= {RW{1'b0}};
            cnt_r    <= {CW{1'b0}};
            result_r <= {RW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        acc_r <= {RW{1'b0}};
                        cnt_r <= {CW{1'b0}};
                    end
                end
                ST_RUN: begin
                    if (abort_s) begin
                        acc_r <= {RW{1'b0}};
                        cnt_r <= {CW{1'b0}};
                    end else if (accept_s) begin
                        acc_r <= step_s;
                        cnt_r <= cnt_r + CW'(1);
                        // result only ever sees the complete reduction
                        if (last_s) begin
                            result_r <= step_s;
                        end
                    end
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end
endmodule
